// File: rtl/prog_sequencer_pkg.sv
// ============================================================================
// proc_pkg : shared types and constants for the processor run controller
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STALL, DONE} seq_state_t;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] c_PROG0_BASE = 16'h0000;
    localparam logic [PC_W-1:0] c_PROG1_BASE = 16'h0100;
    localparam logic [PC_W-1:0] c_PROG2_BASE = 16'h0200;

    // Select 3 has no program of its own and aliases program 0
    function automatic logic [PC_W-1:0] prog_base(
        input logic [1:0]      sel,
        input logic [PC_W-1:0] b0,
        input logic [PC_W-1:0] b1,
        input logic [PC_W-1:0] b2
    );
        case (sel)
            2'd1:    return b1;
            2'd2:    return b2;
            default: return b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_sequencer_if.sv
// ============================================================================
// prog_sequencer_if : control/status bundle between run control and the IF stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface prog_sequencer_if #(
    parameter int CNT_W = 32
);
    import proc_pkg::*;

    logic             Start;
    logic [1:0]       Prog_sel;
    logic             Halt_instr;
    logic             Mem_busy;
    logic             PC_load;
    logic [PC_W-1:0]  Start_addr;
    logic             Fetch_en;
    logic             Busy;
    logic             Done;
    logic             Timeout;
    logic [CNT_W-1:0] Cycle_count;
    logic [CNT_W-1:0] Instr_count;

    modport master (
        output Start, Prog_sel, Halt_instr, Mem_busy,
        input  PC_load, Start_addr, Fetch_en, Busy, Done, Timeout,
               Cycle_count, Instr_count
    );

    modport slave (
        input  Start, Prog_sel, Halt_instr, Mem_busy,
        output PC_load, Start_addr, Fetch_en, Busy, Done, Timeout,
               Cycle_count, Instr_count
    );

endinterface

`default_nettype wire

// File: rtl/prog_sequencer_sat_counter.sv
// ============================================================================
// sat_counter : clearable up-counter that sticks at all-ones instead of wrapping
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         Init_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (!Init_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_sequencer.sv
// ============================================================================
// prog_sequencer : IF-stage run controller (program load, stall gating, halt,
//                  watchdog, cycle/instruction statistics)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module prog_sequencer
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] PROG0_BASE = c_PROG0_BASE,
    parameter logic [PC_W-1:0] PROG1_BASE = c_PROG1_BASE,
    parameter logic [PC_W-1:0] PROG2_BASE = c_PROG2_BASE,
    parameter int              CNT_W      = 32,
    parameter logic [31:0]     MAX_CYCLES = 32'd100000
) (
    input  logic              CLK,
    input  logic              Init_n,
    prog_sequencer_if.slave   bus
);

    localparam logic [2:0] c_ST_IDLE  = IDLE;
    localparam logic [2:0] c_ST_LOAD  = LOAD;
    localparam logic [2:0] c_ST_RUN   = RUN;
    localparam logic [2:0] c_ST_STALL = STALL;
    localparam logic [2:0] c_ST_DONE  = DONE;

    // Watchdog fires on the last permitted cycle so the count ends at MAX_CYCLES
    localparam logic [CNT_W-1:0] c_WD_LAST = CNT_W'(MAX_CYCLES - 32'd1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_timeout;
    logic [PC_W-1:0]  r_start_addr;
    logic [CNT_W-1:0] w_cycle_cnt;
    logic [CNT_W-1:0] w_instr_cnt;
    logic             w_active;
    logic             w_wd_hit;
    logic             w_launch;
    logic             w_retire;

    assign w_active = (r_state == c_ST_RUN) || (r_state == c_ST_STALL);
    assign w_wd_hit = w_active && (w_cycle_cnt == c_WD_LAST);
    assign w_launch = ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && bus.Start;
    // A halt retires too; a stalled instruction retires only when re-presented
    assign w_retire = (r_state == c_ST_RUN) && !w_wd_hit && !bus.Mem_busy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.Start) w_next = c_ST_LOAD;
            c_ST_LOAD:  w_next = c_ST_RUN;
            c_ST_RUN: begin
                if (w_wd_hit)            w_next = c_ST_DONE;
                else if (bus.Mem_busy)   w_next = c_ST_STALL;
                else if (bus.Halt_instr) w_next = c_ST_DONE;
            end
            c_ST_STALL: begin
                if (w_wd_hit)           w_next = c_ST_DONE;
                else if (!bus.Mem_busy) w_next = c_ST_RUN;
            end
            c_ST_DONE:  if (bus.Start) w_next = c_ST_LOAD;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Init_n) begin
            r_state      <= c_ST_IDLE;
            r_timeout    <= 1'b0;
            r_start_addr <= PROG0_BASE;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_timeout    <= 1'b0;
                r_start_addr <= prog_base(bus.Prog_sel, PROG0_BASE, PROG1_BASE, PROG2_BASE);
            end else if (w_wd_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .CLK    (CLK),
        .Init_n (Init_n),
        .clear  (w_launch),
        .inc    (w_active),
        .count  (w_cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .CLK    (CLK),
        .Init_n (Init_n),
        .clear  (w_launch),
        .inc    (w_retire),
        .count  (w_instr_cnt)
    );

    assign bus.PC_load     = (r_state == c_ST_LOAD);
    assign bus.Start_addr  = r_start_addr;
    assign bus.Fetch_en    = w_retire && !bus.Halt_instr;
    assign bus.Busy        = (r_state == c_ST_LOAD) || w_active;
    assign bus.Done        = (r_state == c_ST_DONE);
    assign bus.Timeout     = r_timeout;
    assign bus.Cycle_count = w_cycle_cnt;
    assign bus.Instr_count = w_instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// ============================================================================
// tb_prog_sequencer : directed self-checking bench for prog_sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_prog_sequencer;
    import proc_pkg::*;

    logic CLK = 1'b0;
    logic Init_n;

    always #5 CLK = ~CLK;

    prog_sequencer_if #(.CNT_W(32)) bus ();

    prog_sequencer #(
        .PROG0_BASE (16'h0000),
        .PROG1_BASE (16'h0100),
        .PROG2_BASE (16'h0200),
        .CNT_W      (32),
        .MAX_CYCLES (32'd20)
    ) dut (
        .CLK    (CLK),
        .Init_n (Init_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic        pcl;
        logic [15:0] addr;
        logic        fe;
        logic        busy;
        logic        done;
        logic        to;
        logic [31:0] cc;
        logic [31:0] ic;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic rn, input logic st, input logic [1:0] sel,
                       input logic h, input logic mb);
        Init_n         = rn;
        bus.Start      = st;
        bus.Prog_sel   = sel;
        bus.Halt_instr = h;
        bus.Mem_busy   = mb;
    endtask

    // Queue the expected outputs for this cycle, compare them mid-cycle,
    // then advance to just after the next rising edge
    task automatic ex(input string tag, input logic pcl, input logic [15:0] addr,
                      input logic fe, input logic busy, input logic done, input logic to,
                      input int cc, input int ic);
        exp_t x;
        sb.push_back('{pcl, addr, fe, busy, done, to, 32'(cc), 32'(ic)});
        @(negedge CLK);
        x = sb.pop_front();
        chk({tag, ".PC_load"},     {31'd0, bus.PC_load},  {31'd0, x.pcl});
        chk({tag, ".Start_addr"},  {16'd0, bus.Start_addr}, {16'd0, x.addr});
        chk({tag, ".Fetch_en"},    {31'd0, bus.Fetch_en}, {31'd0, x.fe});
        chk({tag, ".Busy"},        {31'd0, bus.Busy},     {31'd0, x.busy});
        chk({tag, ".Done"},        {31'd0, bus.Done},     {31'd0, x.done});
        chk({tag, ".Timeout"},     {31'd0, bus.Timeout},  {31'd0, x.to});
        chk({tag, ".Cycle_count"}, bus.Cycle_count,       x.cc);
        chk({tag, ".Instr_count"}, bus.Instr_count,       x.ic);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit observed=expired expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        drv(0, 0, 2'd0, 0, 0);
        @(posedge CLK);
        #1;
        // Reset held with Start asserted: stays idle at reset values
        drv(0, 1, 2'd1, 0, 0);
        ex("rst", 0, 16'h0000, 0, 0, 0, 0, 0, 0);

        // Program 1: ten plain instructions then halt
        drv(1, 1, 2'd1, 0, 0);
        ex("idle_start", 0, 16'h0000, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 2'd0, 0, 0);
        ex("load1", 1, 16'h0100, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) ex("run1", 0, 16'h0100, 1, 1, 0, 0, i, i);
        drv(1, 0, 2'd0, 1, 0);
        ex("halt1", 0, 16'h0100, 0, 1, 0, 0, 10, 10);
        drv(1, 1, 2'd2, 0, 0);
        ex("done1", 0, 16'h0100, 0, 0, 1, 0, 11, 11);

        // Program 2: stall with a halt pending underneath it
        drv(1, 0, 2'd0, 0, 0);
        ex("load2", 1, 16'h0200, 0, 1, 0, 0, 0, 0);
        ex("run2a", 0, 16'h0200, 1, 1, 0, 0, 0, 0);
        ex("run2b", 0, 16'h0200, 1, 1, 0, 0, 1, 1);
        drv(1, 0, 2'd0, 1, 1);
        ex("stall_in", 0, 16'h0200, 0, 1, 0, 0, 2, 2);
        ex("stall_a", 0, 16'h0200, 0, 1, 0, 0, 3, 2);
        drv(1, 0, 2'd0, 0, 1);
        ex("stall_b", 0, 16'h0200, 0, 1, 0, 0, 4, 2);
        drv(1, 0, 2'd0, 1, 0);
        ex("stall_exit", 0, 16'h0200, 0, 1, 0, 0, 5, 2);
        ex("halt2", 0, 16'h0200, 0, 1, 0, 0, 6, 2);
        drv(1, 1, 2'd1, 0, 0);
        ex("done2", 0, 16'h0200, 0, 0, 1, 0, 7, 3);

        // Program 1 again: never halts, watchdog ends it; Start mid-run ignored
        drv(1, 0, 2'd0, 0, 0);
        ex("load3", 1, 16'h0100, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) begin
            drv(1, (i == 5), 2'd2, 0, 0);
            ex("run3", 0, 16'h0100, 1, 1, 0, 0, i, i);
        end
        drv(1, 0, 2'd0, 0, 0);
        ex("wd", 0, 16'h0100, 0, 1, 0, 0, 19, 19);
        ex("done3", 0, 16'h0100, 0, 0, 1, 1, 20, 19);
        drv(1, 1, 2'd3, 0, 0);
        ex("done3_hold", 0, 16'h0100, 0, 0, 1, 1, 20, 19);

        // Select 3 aliases program 0; counters and Timeout clear on launch
        drv(1, 0, 2'd0, 0, 0);
        ex("load4", 1, 16'h0000, 0, 1, 0, 0, 0, 0);
        ex("run4", 0, 16'h0000, 1, 1, 0, 0, 0, 0);
        drv(1, 0, 2'd0, 1, 0);
        ex("halt4", 0, 16'h0000, 0, 1, 0, 0, 1, 1);
        drv(1, 1, 2'd2, 0, 0);
        ex("done4", 0, 16'h0000, 0, 0, 1, 0, 2, 2);

        // Reset during a stall aborts straight to idle
        drv(1, 1, 2'd1, 0, 0);
        ex("load5", 1, 16'h0200, 0, 1, 0, 0, 0, 0);
        drv(1, 0, 2'd0, 0, 1);
        ex("stall_entry", 0, 16'h0200, 0, 1, 0, 0, 0, 0);
        drv(0, 1, 2'd1, 0, 1);
        ex("stall_rst", 0, 16'h0200, 0, 1, 0, 0, 1, 0);
        drv(1, 0, 2'd0, 0, 0);
        ex("after_rst", 0, 16'h0000, 0, 0, 0, 0, 0, 0);
        ex("idle_hold", 0, 16'h0000, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller for the single-cycle processor's instruction-fetch stage. Accepts a start request with a program select, loads that program's start address into the PC, and gates PC advance (fetch enable) around data-memory stalls. Detects the halt instruction and reports completion with cycle and instruction counts, plus a watchdog timeout. Sits between the testbench/top-level control and the IF stage, replacing direct drive of the IF stage's Init and Halt inputs.

## Interface
- PROG0_BASE, 16'h0000, start address for program 0 (Prog_sel 0 and 3)
- PROG1_BASE, 16'h0100, start address for program 1
- PROG2_BASE, 16'h0200, start address for program 2
- CNT_W, 32, width of both counters
- MAX_CYCLES, 32'd100000, watchdog limit on run+stall cycles
- CLK  in  1  clock, all state changes on posedge
- Init_n  in  1  synchronous active-low reset
- Start  in  1  run request; sampled only in IDLE and DONE
- Prog_sel  in  2  program select; sampled in the Start cycle
- Halt_instr  in  1  decoder flags the current instruction as halt
- Mem_busy  in  1  data memory not ready; PC must hold
- PC_load  out  1  one-cycle pulse: IF loads Start_addr into PC
- Start_addr  out  16  registered base address of the selected program
- Fetch_en  out  1  1: PC advances this edge; 0: PC holds (IF Halt = ~Fetch_en)
- Busy  out  1  high in LOAD, RUN, STALL
- Done  out  1  high in DONE only
- Timeout  out  1  sticky; set when the watchdog ends the run
- Cycle_count  out  CNT_W  cycles spent in RUN+STALL for the current/last run
- Instr_count  out  CNT_W  instructions retired in the current/last run

## Operation
- States: IDLE, LOAD, RUN, STALL, DONE.
- IDLE: Start=1 -> LOAD; latch Start_addr from Prog_sel; clear both counters and Timeout.
- LOAD: PC_load=1, Fetch_en=0; -> RUN unconditionally.
- RUN, evaluated in priority order:
  - watchdog: Cycle_count == MAX_CYCLES-1 -> DONE, set Timeout.
  - Mem_busy=1 -> STALL, Fetch_en=0. Mem_busy beats Halt_instr; the held PC re-presents the halt after the stall.
  - Halt_instr=1 -> DONE, Fetch_en=0, Instr_count += 1.
  - otherwise Fetch_en=1, Instr_count += 1.
- STALL: Fetch_en=0. Mem_busy=0 -> RUN. Watchdog also applies here.
- DONE: Done=1, Fetch_en=0; counters and Timeout hold. Start=1 -> LOAD, with the same latching and clearing as in IDLE.
- Cycle_count += 1 every cycle in RUN or STALL. Both counters saturate at all-ones and never wrap.
- Prog_sel=3 maps to PROG0_BASE. Start is ignored in LOAD, RUN and STALL.

## Timing
- Reset (Init_n=0 at posedge, from any state): state IDLE; PC_load=0, Fetch_en=0, Busy=0, Done=0, Timeout=0, Start_addr=PROG0_BASE, counters=0.
- All outputs are registered state or decoded from state, Halt_instr and Mem_busy.
  - Fetch_en depends combinationally on Halt_instr/Mem_busy in RUN, so the IF stage sees the freeze in the same cycle.
- Start at edge N -> PC_load high in cycle N+1 -> PC = Start_addr and Fetch_en live in cycle N+2.
- Halt seen at edge M: Done=1 from M+1. The PC holds at the halt address.
- Reset mid-run aborts immediately. There is no drain.

## Structure
- Shared package proc_pkg holds:
  - typedef enum logic[2:0] seq_state_t {IDLE, LOAD, RUN, STALL, DONE}
  - localparam PC_W = 16
  - default program base constants
- One natural sub-module: sat_counter (parameter W; ports: clear, inc, count), instantiated twice.
- FSM and output decode stay in prog_sequencer.

## Test plan
- Reset then Start=1, Prog_sel=1:
  - PC_load pulses one cycle with Start_addr=16'h0100.
  - Fetch_en=1 from the next cycle.
  - Busy=1 throughout.
- Run 10 plain instructions, then Halt_instr=1 -> Done=1 next cycle, Instr_count=11, Cycle_count=11, Fetch_en=0.
- Mem_busy high 3 cycles mid-run, with Halt_instr=1 on the first of them:
  - Fetch_en=0 for 3 cycles.
  - No Done until Mem_busy falls and the halt is re-seen.
  - Cycle_count includes the 3 stall cycles.
- MAX_CYCLES=20, Halt_instr never asserted -> DONE after 20 cycles with Timeout=1, Cycle_count=20.
- In DONE, Start=1, Prog_sel=3:
  - LOAD with Start_addr=16'h0000.
  - Counters and Timeout cleared.
  - Done falls.
- Init_n=0 during STALL -> IDLE next cycle, all outputs at reset values, Start during reset ignored.
